// File: rtl/autobaud_ctrl.sv
// Autobaud controller: times the first UART start bit on rx, derives the 12-bit
// divisor for the 16x-oversampling baud generator, skips the calibration character, then locks.
module autobaud_ctrl #(
    parameter logic [11:0] DEFAULT_DVSR = 12'd326,
    parameter int unsigned IDLE_CYC     = 1024,
    parameter int unsigned MIN_CYC      = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        relock,
    output logic [11:0] baud_dvsr,
    output logic        dvsr_valid,
    output logic        locked,
    output logic        err
);

    localparam logic [15:0] IDLE_W = 16'(IDLE_CYC);
    localparam logic [15:0] MIN_W  = 16'(MIN_CYC);
    localparam logic [15:0] N_LAST = 16'hFFFE;

    typedef enum logic [2:0] {QUAL, ARM, MEAS, SKIP, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        rx_meta, rx_s;
    logic [15:0] qual_q, qual_d;
    logic [15:0] n_q, n_d;
    logic [15:0] per_q, per_d;
    logic [3:0]  bit_q, bit_d;
    logic [11:0] dvsr_d;
    logic        valid_d, locked_d, err_d;
    logic [16:0] d_sum;
    logic [12:0] d_div;
    logic [11:0] d_sat;

    // NOTE: the synchronizer resets to the idle (high) level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Rounded divide by 16, saturated to the 12-bit divisor range.
    assign d_sum = {1'b0, n_q} + 17'd8;
    assign d_div = 13'(d_sum >> 4);
    assign d_sat = d_div[12] ? 12'hFFF : d_div[11:0];

    // NOTE: every next-state variable gets its default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        qual_d   = qual_q;
        n_d      = n_q;
        per_d    = per_q;
        bit_d    = bit_q;
        dvsr_d   = baud_dvsr;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = locked;

        if (relock) begin
            state_d  = QUAL;
            qual_d   = '0;
            n_d      = '0;
            per_d    = '0;
            bit_d    = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                QUAL: begin
                    if (rx_s) begin
                        qual_d = qual_q + 16'd1;
                        if ((qual_q + 16'd1) == IDLE_W) begin
                            qual_d  = '0;
                            state_d = ARM;
                        end
                    end else begin
                        qual_d = '0;
                    end
                end
                ARM: begin
                    if (!rx_s) begin
                        n_d     = 16'd1;
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    if (rx_s) begin
                        if (n_q >= MIN_W) begin
                            dvsr_d  = d_sat;
                            valid_d = 1'b1;
                            per_d   = n_q;
                            bit_d   = 4'd9;
                            state_d = SKIP;
                        end else begin
                            err_d   = 1'b1;
                            n_d     = '0;
                            state_d = ARM;
                        end
                    end else if (n_q == N_LAST) begin
                        err_d   = 1'b1;
                        n_d     = '0;
                        state_d = QUAL;
                    end else begin
                        n_d = n_q + 16'd1;
                    end
                end
                SKIP: begin
                    // One bit period elapses each time the period counter wraps through 1.
                    if (per_q == 16'd1) begin
                        per_d = n_q;
                        bit_d = bit_q - 4'd1;
                        if (bit_q == 4'd1) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        per_d = per_q - 16'd1;
                    end
                end
                LOCKED: locked_d = 1'b1;
                default: state_d = QUAL;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= QUAL;
            qual_q     <= '0;
            n_q        <= '0;
            per_q      <= '0;
            bit_q      <= '0;
            baud_dvsr  <= DEFAULT_DVSR;
            dvsr_valid <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            qual_q     <= qual_d;
            n_q        <= n_d;
            per_q      <= per_d;
            bit_q      <= bit_d;
            baud_dvsr  <= dvsr_d;
            dvsr_valid <= valid_d;
            locked     <= locked_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_autobaud_ctrl.sv
// Self-checking bench for autobaud_ctrl: start-bit widths are checked against an
// arithmetic model of the divisor rule, the 9*N lock delay and the glitch/overflow rules.
module tb_autobaud_ctrl;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        rx     = 1'b1;
    logic        relock = 1'b0;
    logic [11:0] baud_dvsr;
    logic        dvsr_valid, locked, err;

    autobaud_ctrl #(
        .DEFAULT_DVSR(12'd326),
        .IDLE_CYC    (1024),
        .MIN_CYC     (256)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .relock    (relock),
        .baud_dvsr (baud_dvsr),
        .dvsr_valid(dvsr_valid),
        .locked    (locked),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Event monitor, sampled on the falling edge.
    int          cyc = 0, valid_cnt = 0, err_cnt = 0, both_cnt = 0, stray_cnt = 0;
    int          valid_cyc = 0, err_cyc = 0, lock_cyc = 0;
    logic [11:0] cap_dvsr = '0, prev_dvsr = '0;
    logic        prev_locked = 1'b0, prev_rst_n = 1'b0;
    logic [11:0] exp_dvsr = 12'd326;

    always @(negedge clk) begin
        cyc++;
        if (dvsr_valid === 1'b1) begin
            valid_cnt++;
            valid_cyc = cyc;
            cap_dvsr  = baud_dvsr;
        end
        if (err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (dvsr_valid === 1'b1 && err === 1'b1) both_cnt++;
        if (rst_n && prev_rst_n && baud_dvsr !== prev_dvsr && dvsr_valid !== 1'b1) stray_cnt++;
        if (locked === 1'b1 && prev_locked !== 1'b1) lock_cyc = cyc;
        prev_dvsr   = baud_dvsr;
        prev_locked = locked;
        prev_rst_n  = rst_n;
    end

    // Reference rule: rounded N/16, saturated to 12 bits.
    function automatic logic [11:0] model_dvsr(input int n);
        int d;
        d = (n + 8) / 16;
        return (d > 4095) ? 12'd4095 : 12'(d);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        tick(n);
    endtask

    task automatic pulse_relock();
        relock = 1'b1;
        tick(1);
        relock = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data, input int len);
        rx = 1'b0;
        tick(len);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            tick(len);
        end
        rx = 1'b1;
        tick(len);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick(2);
        total++; if (baud_dvsr !== 12'd326) begin bad++; $display("FAIL reset_dvsr: got %0d want 326", baud_dvsr); end
        total++; if (dvsr_valid !== 1'b0)   begin bad++; $display("FAIL reset_valid: got %b want 0", dvsr_valid); end
        total++; if (locked !== 1'b0)       begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        total++; if (err !== 1'b0)          begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n = 1'b1;
        tick(2);
        total++; if (baud_dvsr !== 12'd326) begin bad++; $display("FAIL post_reset_dvsr: got %0d want 326", baud_dvsr); end
        total++; if (locked !== 1'b0)       begin bad++; $display("FAIL post_reset_locked: got %b want 0", locked); end
    endtask

    task automatic test_idle_qual();
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        repeat (2) begin
            rx = 1'b0; tick(600);
            rx = 1'b1; tick(200);
        end
        total++; if (valid_cnt !== v0) begin bad++; $display("FAIL idle_qual_valid: got %0d pulses want 0", valid_cnt - v0); end
        total++; if (err_cnt !== e0)   begin bad++; $display("FAIL idle_qual_err: got %0d pulses want 0", err_cnt - e0); end
        total++; if (locked !== 1'b0)  begin bad++; $display("FAIL idle_qual_locked: got %b want 0", locked); end
    endtask

    task automatic test_glitch_9600();
        int g, f, e0;
        e0 = err_cnt;
        idle(1040);
        g = $urandom_range(200, 16);
        rx = 1'b0; tick(g);
        rx = 1'b1; tick(3);
        total++; if (err !== 1'b1)         begin bad++; $display("FAIL glitch_err: got %b want 1 (width %0d)", err, g); end
        total++; if (dvsr_valid !== 1'b0)  begin bad++; $display("FAIL glitch_valid: got %b want 0", dvsr_valid); end
        total++; if (baud_dvsr !== exp_dvsr) begin bad++; $display("FAIL glitch_dvsr: got %0d want %0d", baud_dvsr, exp_dvsr); end
        tick(200);
        total++; if (err_cnt !== e0 + 1)   begin bad++; $display("FAIL glitch_err_count: got %0d want 1", err_cnt - e0); end
        rx = 1'b0; f = cyc; tick(5208);
        rx = 1'b1; tick(3);
        total++; if (dvsr_valid !== 1'b1)  begin bad++; $display("FAIL b9600_valid: got %b want 1", dvsr_valid); end
        total++; if (baud_dvsr !== model_dvsr(5208)) begin bad++; $display("FAIL b9600_dvsr: got %0d want %0d", baud_dvsr, model_dvsr(5208)); end
        total++; if (valid_cyc !== f + 5208 + 3) begin bad++; $display("FAIL b9600_latency: got %0d want %0d", valid_cyc - f, 5208 + 3); end
        total++; if (err_cnt !== e0 + 1)   begin bad++; $display("FAIL b9600_err_count: got %0d want 1", err_cnt - e0); end
        exp_dvsr = model_dvsr(5208);
        pulse_relock();
    endtask

    task automatic test_lock_115200();
        int f, e0;
        e0 = err_cnt;
        idle(1040);
        f = cyc;
        send_frame(8'h55, 434);
        for (int i = 0; i < 200 && locked !== 1'b1; i++) tick(1);
        total++; if (locked !== 1'b1)      begin bad++; $display("FAIL b115200_locked: got %b want 1", locked); end
        total++; if (baud_dvsr !== model_dvsr(434)) begin bad++; $display("FAIL b115200_dvsr: got %0d want %0d", baud_dvsr, model_dvsr(434)); end
        total++; if (cap_dvsr !== model_dvsr(434))  begin bad++; $display("FAIL b115200_cap: got %0d want %0d", cap_dvsr, model_dvsr(434)); end
        total++; if (valid_cyc !== f + 437) begin bad++; $display("FAIL b115200_latency: got %0d want 437", valid_cyc - f); end
        total++; if (lock_cyc - valid_cyc !== 9 * 434) begin bad++; $display("FAIL b115200_lock_delay: got %0d want %0d", lock_cyc - valid_cyc, 9 * 434); end
        total++; if (err_cnt !== e0)       begin bad++; $display("FAIL b115200_err: got %0d pulses want 0", err_cnt - e0); end
        exp_dvsr = model_dvsr(434);
    endtask

    task automatic test_relock_meas();
        int v0, e0;
        pulse_relock();
        total++; if (locked !== 1'b0)        begin bad++; $display("FAIL relock_locked: got %b want 0", locked); end
        total++; if (baud_dvsr !== exp_dvsr) begin bad++; $display("FAIL relock_dvsr: got %0d want %0d", baud_dvsr, exp_dvsr); end
        idle(1040);
        v0 = valid_cnt;
        e0 = err_cnt;
        rx = 1'b0; tick(300);
        pulse_relock();
        tick(100);
        rx = 1'b1; tick(20);
        total++; if (valid_cnt !== v0) begin bad++; $display("FAIL relock_meas_valid: got %0d pulses want 0", valid_cnt - v0); end
        total++; if (err_cnt !== e0)   begin bad++; $display("FAIL relock_meas_err: got %0d pulses want 0", err_cnt - e0); end
        tick(500);
        rx = 1'b0; tick(300);
        rx = 1'b1; tick(10);
        total++; if (valid_cnt !== v0) begin bad++; $display("FAIL relock_requal: got %0d pulses want 0", valid_cnt - v0); end
        total++; if (locked !== 1'b0)  begin bad++; $display("FAIL relock_requal_locked: got %b want 0", locked); end
    endtask

    task automatic test_stuck_low();
        int f, v0, e0;
        idle(1040);
        v0 = valid_cnt;
        e0 = err_cnt;
        rx = 1'b0; f = cyc;
        tick(65545);
        total++; if (err_cnt !== e0 + 1)       begin bad++; $display("FAIL stuck_err_count: got %0d want 1", err_cnt - e0); end
        total++; if (err_cyc !== f + 65537)    begin bad++; $display("FAIL stuck_err_time: got %0d want 65537", err_cyc - f); end
        total++; if (baud_dvsr !== exp_dvsr)   begin bad++; $display("FAIL stuck_dvsr: got %0d want %0d", baud_dvsr, exp_dvsr); end
        rx = 1'b1; tick(500);
        rx = 1'b0; tick(300);
        rx = 1'b1; tick(10);
        total++; if (valid_cnt !== v0)         begin bad++; $display("FAIL stuck_requal_valid: got %0d pulses want 0", valid_cnt - v0); end
        total++; if (err_cnt !== e0 + 1)       begin bad++; $display("FAIL stuck_requal_err: got %0d want 1", err_cnt - e0); end
        total++; if (locked !== 1'b0)          begin bad++; $display("FAIL stuck_locked: got %b want 0", locked); end
    endtask

    task automatic test_random_widths();
        int widths[4];
        widths[0] = 255;
        widths[1] = 256;
        widths[2] = $urandom_range(600, 257);
        widths[3] = $urandom_range(255, 16);
        for (int k = 0; k < 4; k++) begin
            pulse_relock();
            idle(1040);
            rx = 1'b0; tick(widths[k]);
            rx = 1'b1; tick(3);
            if (widths[k] >= 256) begin
                total++; if (dvsr_valid !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL width_%0d_pulses: got valid=%b err=%b want valid=1 err=0", widths[k], dvsr_valid, err); end
                exp_dvsr = model_dvsr(widths[k]);
            end else begin
                total++; if (err !== 1'b1 || dvsr_valid !== 1'b0) begin bad++; $display("FAIL width_%0d_pulses: got valid=%b err=%b want valid=0 err=1", widths[k], dvsr_valid, err); end
            end
            total++; if (baud_dvsr !== exp_dvsr) begin bad++; $display("FAIL width_%0d_dvsr: got %0d want %0d", widths[k], baud_dvsr, exp_dvsr); end
        end
    endtask

    task automatic test_reset_skip();
        int v0, e0;
        pulse_relock();
        idle(1040);
        rx = 1'b0; tick(300);
        rx = 1'b1; tick(3);
        total++; if (baud_dvsr !== model_dvsr(300)) begin bad++; $display("FAIL skip_dvsr: got %0d want %0d", baud_dvsr, model_dvsr(300)); end
        tick(200);
        rst_n = 1'b0;
        #1;
        total++; if (locked !== 1'b0)       begin bad++; $display("FAIL skip_reset_locked: got %b want 0", locked); end
        total++; if (baud_dvsr !== 12'd326) begin bad++; $display("FAIL skip_reset_dvsr: got %0d want 326", baud_dvsr); end
        exp_dvsr = 12'd326;
        tick(2);
        rst_n = 1'b1;
        v0 = valid_cnt;
        e0 = err_cnt;
        tick(500);
        rx = 1'b0; tick(300);
        rx = 1'b1; tick(10);
        total++; if (valid_cnt !== v0 || err_cnt !== e0) begin bad++; $display("FAIL skip_reset_requal: got valid=%0d err=%0d pulses want 0", valid_cnt - v0, err_cnt - e0); end
        total++; if (baud_dvsr !== exp_dvsr) begin bad++; $display("FAIL skip_reset_hold: got %0d want %0d", baud_dvsr, exp_dvsr); end
    endtask

    task automatic test_integrity();
        total++; if (both_cnt !== 0)  begin bad++; $display("FAIL valid_err_overlap: got %0d cycles want 0", both_cnt); end
        total++; if (stray_cnt !== 0) begin bad++; $display("FAIL dvsr_change_without_valid: got %0d want 0", stray_cnt); end
    endtask

    initial begin
        test_reset();
        test_idle_qual();
        test_glitch_9600();
        test_lock_115200();
        test_relock_meas();
        test_stuck_low();
        test_random_widths();
        test_reset_skip();
        test_integrity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
